// File: rtl/imem_loader_if.sv
// Boot loader bus bundle: inbound byte stream plus the instruction memory write port.
// The loader side uses the slave modport; the byte source / memory side uses master.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: length-prefixed byte stream -> 32-bit little-endian words
// written to instruction memory, followed by an XOR checksum byte that releases the CPU.
module imem_loader #(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t          state;
  logic [15:0]     len_q;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_acc;
  logic [7:0]      csum;
  logic            xfer;
  logic [15:0]     n_full;
  logic [ADDR_W:0] ww_inc;
  logic [15:0]     ww_inc_ext;

  // A byte moves on a posedge where in_valid && in_ready; in_ready is decoded from
  // the state register only, so it never depends combinationally on in_valid.
  assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CSUM);
  assign xfer       = bus.in_valid && bus.in_ready;
  assign n_full     = {bus.in_data, len_q[7:0]};
  assign ww_inc     = words_written + {{ADDR_W{1'b0}}, 1'b1};
  assign ww_inc_ext = {{(15 - ADDR_W){1'b0}}, ww_inc};

  assign bus.mem_we = (state == WRITE);
  assign busy       = bus.in_ready || (state == WRITE);
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign cpu_hold   = (state != DONE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      len_q         <= '0;
      byte_cnt      <= '0;
      word_acc      <= '0;
      csum          <= '0;
      words_written <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= LEN_LO;
            len_q         <= '0;
            byte_cnt      <= '0;
            csum          <= '0;
            words_written <= '0;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= bus.in_data;
            state      <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_q <= n_full;
            if (n_full > DEPTH16)    state <= ERR;
            else if (n_full == 16'd0) state <= CSUM;
            else                      state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            csum     <= csum ^ bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_acc[7:0]   <= bus.in_data;
              2'd1: word_acc[15:8]  <= bus.in_data;
              2'd2: word_acc[23:16] <= bus.in_data;
              default: begin
                // Fourth byte completes the word; latch the write port for WRITE.
                bus.mem_addr  <= words_written[ADDR_W-1:0];
                bus.mem_wdata <= {bus.in_data, word_acc};
                state         <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          words_written <= ww_inc;
          byte_cnt      <= '0;
          state         <= (ww_inc_ext == len_q) ? CSUM : DATA;
        end
        CSUM: begin
          if (xfer) state <= (bus.in_data == csum) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
